// File: rtl/bd_pkg.sv
// Shared encodings for the block-device port: command codes, host FSM states
// and block geometry defaults.
package bd_pkg;

   localparam logic [1:0] BD_CMD_IDLE  = 2'b00;
   localparam logic [1:0] BD_CMD_READ  = 2'b01;
   localparam logic [1:0] BD_CMD_WRITE = 2'b10;

   localparam int BD_WORDS_PER_BLK = 256;
   localparam int BD_TIMEOUT       = 1000000;
   localparam int BD_TMO_W         = 24;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RDY  = 3'd1,
      START     = 3'd2,
      WAIT_BSY  = 3'd3,
      XFER      = 3'd4,
      WAIT_DONE = 3'd5,
      DONE      = 3'd6,
      ERR       = 3'd7
   } bd_state_e;

   function automatic logic [1:0] bd_cmd_enc(input logic is_write);
      return is_write ? BD_CMD_WRITE : BD_CMD_READ;
   endfunction

endpackage

// File: rtl/bd_host_ctrl.sv
// Host end of the block-device port: sequences one-block read/write commands
// and streams 16-bit words between the client and the device.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting a client request
// WAIT_RDY  | waiting for device ready and not busy
// START     | one-cycle command strobe to the device
// WAIT_BSY  | waiting for the device to accept (busy) or reject (err)
// XFER      | moving words, one per strobe
// WAIT_DONE | last word moved; waiting for device idle and read drain
// DONE      | one-cycle completion pulse
// ERR       | one-cycle abort pulse, read holding register flushed
module bd_host_ctrl
   import bd_pkg::*;
#(
   parameter int WORDS_PER_BLK = BD_WORDS_PER_BLK,
   parameter int TIMEOUT       = BD_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [23:0] req_addr,
   output logic        req_ready,
   input  logic [15:0] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   input  logic        rdata_ready,
   output logic        done,
   output logic        err,
   output logic        err_timeout,
   output logic [1:0]  bd_cmd,
   output logic        bd_start,
   input  logic        bd_bsy,
   input  logic        bd_rdy,
   input  logic        bd_err,
   output logic [23:0] bd_addr,
   output logic [15:0] bd_data_in,
   input  logic [15:0] bd_data_out,
   output logic        bd_rd,
   output logic        bd_wr,
   input  logic        bd_iordy
);

   localparam int CNT_W = $clog2(WORDS_PER_BLK) + 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WORDS_PER_BLK - 1);
   localparam logic [BD_TMO_W-1:0] TMO_LAST = BD_TMO_W'(TIMEOUT - 1);

   bd_state_e            state_q, state_d;
   logic                 write_q, write_d;
   logic [23:0]          addr_q, addr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BD_TMO_W-1:0]  tmo_q, tmo_d;
   logic [15:0]          rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 err_tmo_q, err_tmo_d;

   logic strobe;
   logic tmo_en;
   logic tmo_hit;

   assign tmo_hit     = (tmo_q == TMO_LAST);
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign err_timeout = err_tmo_q;

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      err_tmo_d   = err_tmo_q;
      strobe      = 1'b0;
      tmo_en      = 1'b0;
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      bd_wr       = 1'b0;
      bd_rd       = 1'b0;
      bd_start    = 1'b0;
      bd_cmd      = BD_CMD_IDLE;
      bd_addr     = 24'd0;
      bd_data_in  = 16'd0;
      done        = 1'b0;
      err         = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            cnt_d     = '0;
            if (req_valid) begin
               write_d   = req_write;
               addr_d    = req_addr;
               err_tmo_d = 1'b0;
               state_d   = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            tmo_en = 1'b1;
            if (bd_rdy && !bd_bsy) begin
               state_d = START;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ERR;
            end
         end
         START: begin
            bd_start = 1'b1;
            state_d  = WAIT_BSY;
         end
         WAIT_BSY: begin
            tmo_en = 1'b1;
            if (bd_bsy) begin
               state_d = XFER;
            end else if (bd_err) begin
               state_d = ERR;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ERR;
            end
         end
         XFER: begin
            tmo_en = 1'b1;
            // A device error masks the strobe in the same cycle it is seen.
            if (write_q) begin
               bd_data_in  = wdata;
               strobe      = bd_iordy & wdata_valid & ~bd_err;
               bd_wr       = strobe;
               wdata_ready = strobe;
            end else begin
               strobe = bd_iordy & (~rvalid_q | rdata_ready) & ~bd_err;
               bd_rd  = strobe;
            end
            if (bd_err) begin
               state_d = ERR;
            end else if (strobe) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = WAIT_DONE;
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ERR;
            end
         end
         WAIT_DONE: begin
            tmo_en = 1'b1;
            if (!bd_bsy && bd_err) begin
               state_d = ERR;
            end else if (!bd_bsy && (write_q || !rvalid_q)) begin
               state_d = DONE;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ERR;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            err     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_q inside {START, WAIT_BSY, XFER, WAIT_DONE}) begin
         bd_cmd  = bd_cmd_enc(write_q);
         bd_addr = addr_q;
      end
   end

   always_comb begin
      tmo_d = '0;
      if (tmo_en && (state_d == state_q) && !strobe) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // One-entry read holding register; a new capture wins over a take.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      if (bd_rd) begin
         rdata_d  = bd_data_out;
         rvalid_d = 1'b1;
      end else if (rdata_ready) begin
         rvalid_d = 1'b0;
      end
      if (state_d == ERR) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         addr_q    <= 24'd0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         rdata_q   <= 16'd0;
         rvalid_q  <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         err_tmo_q <= err_tmo_d;
      end
   end

endmodule

// File: tb/tb_bd_host_ctrl.sv
// Directed bench for bd_host_ctrl with a behavioural block device and
// queue-based scoreboards for read and write data.
module tb_bd_host_ctrl;
   import bd_pkg::*;

   localparam int NW  = 256;
   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [23:0] req_addr = 24'd0;
   logic        req_ready;
   logic [15:0] wdata = 16'd0;
   logic        wdata_valid = 1'b0;
   logic        wdata_ready;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        rdata_ready = 1'b1;
   logic        done;
   logic        err;
   logic        err_timeout;
   logic [1:0]  bd_cmd;
   logic        bd_start;
   logic        bd_bsy = 1'b0;
   logic        bd_rdy = 1'b0;
   logic        bd_err = 1'b0;
   logic [23:0] bd_addr;
   logic [15:0] bd_data_in;
   logic [15:0] bd_data_out = 16'd0;
   logic        bd_rd;
   logic        bd_wr;
   logic        bd_iordy = 1'b0;

   always #5 clk = ~clk;

   bd_host_ctrl #(.WORDS_PER_BLK(NW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_ready(req_ready),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
      .done(done), .err(err), .err_timeout(err_timeout),
      .bd_cmd(bd_cmd), .bd_start(bd_start), .bd_bsy(bd_bsy), .bd_rdy(bd_rdy),
      .bd_err(bd_err), .bd_addr(bd_addr), .bd_data_in(bd_data_in),
      .bd_data_out(bd_data_out), .bd_rd(bd_rd), .bd_wr(bd_wr),
      .bd_iordy(bd_iordy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pat(input int i);
      return 16'hC000 + 16'(i * 7);
   endfunction

   logic [66:0] outs;
   logic [66:0] outs_rst;
   assign outs = {req_ready, wdata_ready, rdata, rdata_valid, done, err, err_timeout,
                  bd_cmd, bd_start, bd_addr, bd_data_in, bd_rd, bd_wr};

   // device model and monitors
   int          phase = 0, dly = 0, dwords = 0, cyc = 0;
   int          start_cnt = 0, done_cnt = 0, err_cnt = 0, rd_pops = 0;
   int          err_at = 0;
   logic        rdy_en = 1'b1;
   logic [1:0]  exp_cmd = 2'b00;
   logic [23:0] exp_addr = 24'd0;
   logic [15:0] exp_rd_q[$];
   logic [15:0] exp_wr_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         phase  <= 0;
         dwords <= 0;
      end else if (bd_start) begin
         start_cnt <= start_cnt + 1;
         chk("start_cmd", 96'(bd_cmd), 96'(exp_cmd));
         chk("start_addr", 96'(bd_addr), 96'(exp_addr));
         phase  <= 1;
         dly    <= 0;
         dwords <= 0;
      end else begin
         case (phase)
            1: begin
               dly <= dly + 1;
               if (dly == 2) phase <= 2;
            end
            2: begin
               if (bd_rd || bd_wr) begin
                  if (bd_wr) begin
                     chk("wr_q_nonempty", 96'(exp_wr_q.size() != 0), 96'(1));
                     if (exp_wr_q.size() != 0) chk("wr_data", 96'(bd_data_in), 96'(exp_wr_q.pop_front()));
                  end
                  dwords <= dwords + 1;
                  if (dwords + 1 == NW) begin
                     phase <= 3;
                     dly   <= 0;
                  end else if (err_at != 0 && dwords + 1 == err_at) begin
                     phase <= 4;
                     dly   <= 0;
                  end
               end
            end
            3: begin
               chk("no_strobe_after_last", 96'({bd_rd, bd_wr}), 96'(0));
               dly <= dly + 1;
               if (dly == 3) phase <= 0;
            end
            4: begin
               chk("strobe_low_on_err", 96'({bd_rd, bd_wr}), 96'(0));
               dly <= dly + 1;
               if (dly == 2) phase <= 0;
            end
            default: ;
         endcase
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         if (done) begin
            done_cnt <= done_cnt + 1;
            chk("done_after_data", 96'(exp_rd_q.size() + exp_wr_q.size()), 96'(0));
         end
         if (err) err_cnt <= err_cnt + 1;
         if (rdata_valid && rdata_ready) begin
            rd_pops <= rd_pops + 1;
            chk("rd_q_nonempty", 96'(exp_rd_q.size() != 0), 96'(1));
            if (exp_rd_q.size() != 0) chk("rd_data", 96'(rdata), 96'(exp_rd_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      bd_rdy      = rdy_en && (phase == 0);
      bd_bsy      = (phase >= 2);
      bd_err      = (phase == 4);
      bd_iordy    = ((phase == 2) && (cyc % 3 != 2)) || (phase == 4);
      bd_data_out = pat(dwords);
   end

   task automatic issue(input logic w, input logic [23:0] a);
      @(negedge clk);
      chk("req_ready_idle", 96'(req_ready), 96'(1));
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int base;
      int n;
      base = done_cnt + err_cnt;
      n = 0;
      while (done_cnt + err_cnt == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("end_within_budget", 96'(n < budget), 96'(1));
      repeat (4) @(negedge clk);
   endtask

   task automatic push_read();
      for (int i = 0; i < NW; i++) exp_rd_q.push_back(pat(i));
   endtask

   int s0, d0, e0, p0, n, idx, w0;
   logic tog;

   initial begin
      outs_rst = {1'b1, 66'd0};
      repeat (3) @(negedge clk);
      chk("reset_outputs", 96'(outs), 96'(outs_rst));
      reset = 1'b0;
      @(negedge clk);

      // plain read
      exp_cmd = BD_CMD_READ; exp_addr = 24'h000123;
      push_read();
      s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; p0 = rd_pops;
      issue(1'b0, 24'h000123);
      wait_end(3000);
      chk("rd_starts", 96'(start_cnt - s0), 96'(1));
      chk("rd_strobes", 96'(dwords), 96'(NW));
      chk("rd_pops", 96'(rd_pops - p0), 96'(NW));
      chk("rd_done", 96'(done_cnt - d0), 96'(1));
      chk("rd_no_err", 96'(err_cnt - e0), 96'(0));

      // write, wdata_valid toggling
      exp_cmd = BD_CMD_WRITE; exp_addr = 24'h0ABCDE;
      for (int i = 0; i < NW; i++) exp_wr_q.push_back(16'(i));
      s0 = start_cnt; d0 = done_cnt;
      issue(1'b1, 24'h0ABCDE);
      idx = 0; n = 0; tog = 1'b0;
      while (idx < NW && n < 4000) begin
         @(negedge clk);
         tog = ~tog;
         wdata_valid = tog;
         wdata = 16'(idx);
         @(posedge clk);
         if (wdata_valid && wdata_ready) idx++;
         n++;
      end
      @(negedge clk);
      wdata_valid = 1'b0;
      wait_end(3000);
      chk("wr_client_words", 96'(idx), 96'(NW));
      chk("wr_strobes", 96'(dwords), 96'(NW));
      chk("wr_q_drained", 96'(exp_wr_q.size()), 96'(0));
      chk("wr_starts", 96'(start_cnt - s0), 96'(1));
      chk("wr_done", 96'(done_cnt - d0), 96'(1));

      // read with a 10-cycle client stall
      exp_cmd = BD_CMD_READ; exp_addr = 24'h000456;
      push_read();
      d0 = done_cnt; p0 = rd_pops;
      issue(1'b0, 24'h000456);
      n = 0;
      while (rd_pops - p0 < 100 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("stall_reach", 96'(n < 2000), 96'(1));
      rdata_ready = 1'b0;
      @(negedge clk);
      w0 = dwords;
      repeat (10) @(negedge clk);
      chk("stall_rd_held", 96'(dwords - w0 <= 1), 96'(1));
      rdata_ready = 1'b1;
      wait_end(3000);
      chk("stall_strobes", 96'(dwords), 96'(NW));
      chk("stall_pops", 96'(rd_pops - p0), 96'(NW));
      chk("stall_done", 96'(done_cnt - d0), 96'(1));

      // device error after 40 words
      err_at = 40;
      exp_addr = 24'h000040;
      push_read();
      d0 = done_cnt; e0 = err_cnt; p0 = rd_pops;
      issue(1'b0, 24'h000040);
      wait_end(3000);
      chk("derr_err", 96'(err_cnt - e0), 96'(1));
      chk("derr_no_done", 96'(done_cnt - d0), 96'(0));
      chk("derr_strobes", 96'(dwords), 96'(40));
      chk("derr_pops_le40", 96'(rd_pops - p0 <= 40), 96'(1));
      chk("derr_err_timeout", 96'(err_timeout), 96'(0));
      chk("derr_req_ready", 96'(req_ready), 96'(1));
      exp_rd_q.delete();
      err_at = 0;

      // timeout in WAIT_RDY
      rdy_en = 1'b0;
      s0 = start_cnt; e0 = err_cnt;
      issue(1'b0, 24'h000555);
      n = 0;
      while (!err && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", 96'(n), 96'(TMO));
      @(negedge clk);
      chk("tmo_sticky", 96'(err_timeout), 96'(1));
      chk("tmo_err", 96'(err_cnt - e0), 96'(1));
      chk("tmo_no_start", 96'(start_cnt - s0), 96'(0));
      rdy_en = 1'b1;
      exp_addr = 24'h000777;
      push_read();
      d0 = done_cnt;
      issue(1'b0, 24'h000777);
      chk("tmo_cleared", 96'(err_timeout), 96'(0));
      wait_end(3000);
      chk("tmo_next_done", 96'(done_cnt - d0), 96'(1));

      // reset mid-transfer
      exp_addr = 24'h000999;
      push_read();
      issue(1'b0, 24'h000999);
      n = 0;
      while (dwords < 20 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_xfer", 96'(n < 2000), 96'(1));
      s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_outputs", 96'(outs), 96'(outs_rst));
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_no_pulse", 96'((done_cnt - d0) + (err_cnt - e0)), 96'(0));
      chk("rst_no_restart", 96'(start_cnt - s0), 96'(0));
      chk("rst_idle", 96'(req_ready), 96'(1));
      exp_rd_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
